// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single data SRAM port between fetch and data memory.
// Ports: clk/rst (sync, active-low), inst_* fetch side, data_* data side,
//   data_sram_* SRAM pins. Fixed priority to data with a fetch starvation guard.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_done,
    output logic        inst_stall,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    output logic        data_stall,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        O_NONE = 2'd0,
        O_INST = 2'd1,
        O_DATA = 2'd2
    } owner_t;

    owner_t      owner;
    logic [3:0]  streak;

    logic        inst_elig;
    logic        data_elig;
    logic        grant_inst;
    logic        grant_data;
    logic        data_rd;
    logic        ret_inst;
    logic        ret_data;
    logic        starved;
    logic [31:0] sel_addr;
    logic        unused_addr_hi;

    always_comb begin
        // A requester whose read is returning this cycle is not eligible;
        // its request is consumed by the return.
        inst_elig  = inst_req && (owner != O_INST);
        data_elig  = data_req && (owner != O_DATA);
        starved    = streak >= 4'(STARVE_LIMIT);
        grant_inst = inst_elig && (starved || !data_elig);
        grant_data = data_elig && !grant_inst;
        data_rd    = (data_wen == 4'b0000);
        ret_inst   = (owner == O_INST);
        ret_data   = (owner == O_DATA);
        sel_addr   = 32'h0;
        if (grant_data) begin
            sel_addr = data_addr;
        end else if (grant_inst) begin
            sel_addr = inst_addr;
        end
    end

    // Upper three address bits are dropped by the physical mapping.
    assign unused_addr_hi = ^sel_addr[31:29];

    assign data_sram_en    = rst && (grant_inst || grant_data);
    assign data_sram_wen   = (rst && grant_data) ? data_wen : 4'b0000;
    assign data_sram_addr  = {3'b000, sel_addr[28:0]};
    assign data_sram_wdata = grant_data ? data_wdata : 32'h0;

    assign inst_done  = rst && ret_inst;
    // A data write completes in its issue cycle; a data read on return.
    assign data_done  = rst && (ret_data || (grant_data && !data_rd));
    assign inst_stall = rst && inst_req && !inst_done;
    assign data_stall = rst && data_req && !data_done;
    assign inst_rdata = inst_done ? data_sram_rdata : 32'h0;
    assign data_rdata = (rst && ret_data) ? data_sram_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner  <= O_NONE;
            streak <= 4'd0;
        end else begin
            if (grant_inst) begin
                owner <= O_INST;
            end else if (grant_data && data_rd) begin
                owner <= O_DATA;
            end else begin
                owner <= O_NONE;
            end

            // Count data grants that keep a still-waiting fetch out.
            if (!inst_req || grant_inst) begin
                streak <= 4'd0;
            end else if (grant_data && !ret_inst && (streak != 4'hF)) begin
                streak <= streak + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (STARVE_LIMIT=2).
// Stimulus pushes expected issues/returns; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        inst_stall;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        data_stall;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'h0;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_done(inst_done),
        .inst_stall(inst_stall),
        .data_req(data_req), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_done(data_done),
        .data_stall(data_stall),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: 0x100 holds 0xDEADBEEF, other words read addr ^ 0x5A5A0000.
    always @(posedge clk) begin
        if (data_sram_en && data_sram_wen == 4'b0000) begin
            if (data_sram_addr == 32'h100)
                data_sram_rdata <= 32'hDEADBEEF;
            else
                data_sram_rdata <= data_sram_addr ^ 32'h5A5A0000;
        end
    end

    typedef struct {
        int          cyc;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        bit          rd;
    } ret_t;

    iss_t iss_q[$];
    ret_t iq[$];
    ret_t dq[$];

    int errs = 0;
    int nchk = 0;

    task automatic chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_iss(int c, logic [3:0] w, logic [31:0] a, logic [31:0] d);
        iss_t e;
        e.cyc = c; e.wen = w; e.addr = a; e.wdata = d;
        iss_q.push_back(e);
    endtask

    task automatic push_ret(bit is_inst, int c, logic [31:0] r, bit rd);
        ret_t e;
        e.cyc = c; e.rdata = r; e.rd = rd;
        if (is_inst) iq.push_back(e);
        else dq.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        iss_t ie;
        ret_t re;
        if (data_sram_en) begin
            if (iss_q.size() == 0) begin
                chk(1'b0, "unexpected_issue", data_sram_addr, 32'h0);
            end else begin
                ie = iss_q.pop_front();
                chk(cyc == ie.cyc, "issue_cycle", cyc, ie.cyc);
                chk(data_sram_addr == ie.addr, "issue_addr", data_sram_addr, ie.addr);
                chk(data_sram_wen == ie.wen, "issue_wen", {28'h0, data_sram_wen}, {28'h0, ie.wen});
                if (ie.wen != 4'b0000)
                    chk(data_sram_wdata == ie.wdata, "issue_wdata", data_sram_wdata, ie.wdata);
            end
        end
        if (inst_done) begin
            if (iq.size() == 0) begin
                chk(1'b0, "unexpected_inst_done", inst_rdata, 32'h0);
            end else begin
                re = iq.pop_front();
                chk(cyc == re.cyc, "inst_done_cycle", cyc, re.cyc);
                chk(inst_rdata == re.rdata, "inst_rdata", inst_rdata, re.rdata);
            end
        end
        if (data_done) begin
            if (dq.size() == 0) begin
                chk(1'b0, "unexpected_data_done", data_rdata, 32'h0);
            end else begin
                re = dq.pop_front();
                chk(cyc == re.cyc, "data_done_cycle", cyc, re.cyc);
                if (re.rd)
                    chk(data_rdata == re.rdata, "data_rdata", data_rdata, re.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        repeat (3) step();
        chk(iss_q.size() == 0, {name, "_issues_left"}, iss_q.size(), 0);
        chk(iq.size() == 0, {name, "_inst_left"}, iq.size(), 0);
        chk(dq.size() == 0, {name, "_data_left"}, dq.size(), 0);
    endtask

    task automatic chk_quiet(string name);
        chk(data_sram_en == 0, {name, "_en"}, {31'h0, data_sram_en}, 0);
        chk(data_sram_wen == 0, {name, "_wen"}, {28'h0, data_sram_wen}, 0);
        chk(inst_done == 0, {name, "_inst_done"}, {31'h0, inst_done}, 0);
        chk(data_done == 0, {name, "_data_done"}, {31'h0, data_done}, 0);
        chk(inst_stall == 0, {name, "_inst_stall"}, {31'h0, inst_stall}, 0);
        chk(data_stall == 0, {name, "_data_stall"}, {31'h0, data_stall}, 0);
        chk(inst_rdata == 0, {name, "_inst_rdata"}, inst_rdata, 0);
        chk(data_rdata == 0, {name, "_data_rdata"}, data_rdata, 0);
    endtask

    int n;

    initial begin
        rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0;
        data_req = 1'b1; data_wen = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;

        // Reset: requests high but every output forced low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        step();
        inst_req = 1'b0; data_req = 1'b0;
        rst = 1'b1;
        step();
        chk(int'(dut.owner) == 0, "reset_owner", int'(dut.owner), 0);
        chk(dut.streak == 0, "reset_streak", {28'h0, dut.streak}, 0);

        // 1: lone fetch read.
        step();
        inst_req = 1'b1; inst_addr = 32'h100;
        n = cyc;
        push_iss(n, 4'h0, 32'h100, 32'h0);
        push_ret(1'b1, n + 1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk(inst_stall == 1, "t1_stall_issue", {31'h0, inst_stall}, 1);
        step();
        @(negedge clk);
        chk(inst_stall == 0, "t1_stall_done", {31'h0, inst_stall}, 0);
        step();
        inst_req = 1'b0;
        drain("t1");

        // 2: data write with address mapping.
        step();
        data_req = 1'b1; data_wen = 4'b0011;
        data_addr = 32'hA0000204; data_wdata = 32'h11223344;
        n = cyc;
        push_iss(n, 4'b0011, 32'h00000204, 32'h11223344);
        push_ret(1'b0, n, 32'h0, 1'b0);
        @(negedge clk);
        chk(data_stall == 0, "t2_stall", {31'h0, data_stall}, 0);
        step();
        data_req = 1'b0; data_wen = 4'h0;
        chk(int'(dut.owner) == 0, "t2_owner", int'(dut.owner), 0);
        drain("t2");

        // 3: simultaneous reads, data wins first.
        step();
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h300;
        inst_req = 1'b1; inst_addr = 32'h200;
        n = cyc;
        push_iss(n, 4'h0, 32'h300, 32'h0);
        push_iss(n + 1, 4'h0, 32'h200, 32'h0);
        push_ret(1'b0, n + 1, 32'h5A5A0300, 1'b1);
        push_ret(1'b1, n + 2, 32'h5A5A0200, 1'b1);
        step();
        step();
        data_req = 1'b0;
        step();
        inst_req = 1'b0;
        drain("t3");

        // 4: starvation guard, limit 2.
        step();
        inst_req = 1'b1; inst_addr = 32'h400;
        data_req = 1'b1; data_wen = 4'hF;
        data_addr = 32'h500; data_wdata = 32'hA0A0A0A0;
        n = cyc;
        push_iss(n, 4'hF, 32'h500, 32'hA0A0A0A0);
        push_ret(1'b0, n, 32'h0, 1'b0);
        push_iss(n + 1, 4'hF, 32'h504, 32'hB1B1B1B1);
        push_ret(1'b0, n + 1, 32'h0, 1'b0);
        push_iss(n + 2, 4'h0, 32'h400, 32'h0);
        push_ret(1'b1, n + 3, 32'h5A5A0400, 1'b1);
        push_iss(n + 3, 4'hF, 32'h508, 32'hC2C2C2C2);
        push_ret(1'b0, n + 3, 32'h0, 1'b0);
        step();
        data_addr = 32'h504; data_wdata = 32'hB1B1B1B1;
        step();
        data_addr = 32'h508; data_wdata = 32'hC2C2C2C2;
        chk(dut.streak == 2, "t4_streak_sat", {28'h0, dut.streak}, 2);
        step();
        chk(dut.streak == 0, "t4_streak_clr", {28'h0, dut.streak}, 0);
        step();
        inst_req = 1'b0; data_req = 1'b0; data_wen = 4'h0;
        drain("t4");

        // 5: reset right after a data read issue.
        step();
        data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h600;
        n = cyc;
        push_iss(n, 4'h0, 32'h600, 32'h0);
        step();
        rst = 1'b0; inst_req = 1'b1; inst_addr = 32'h104;
        @(negedge clk);
        chk_quiet("t5_rst_a");
        step();
        @(negedge clk);
        chk_quiet("t5_rst_b");
        step();
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        chk(int'(dut.owner) == 0, "t5_owner", int'(dut.owner), 0);
        step();
        data_req = 1'b1; data_addr = 32'h700;
        n = cyc;
        push_iss(n, 4'h0, 32'h700, 32'h0);
        push_ret(1'b0, n + 1, 32'h5A5A0700, 1'b1);
        step();
        step();
        data_req = 1'b0;
        drain("t5");

        // 6: fetch request held continuously.
        step();
        inst_req = 1'b1; inst_addr = 32'h800;
        n = cyc;
        for (int k = 0; k < 3; k++) begin
            push_iss(n + 2 * k, 4'h0, 32'h800, 32'h0);
            push_ret(1'b1, n + 2 * k + 1, 32'h5A5A0800, 1'b1);
        end
        repeat (6) step();
        inst_req = 1'b0;
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
